// File: rtl/wide_add_seq.sv
// wide_add_seq: WIDTH-bit addition computed one SLICE-bit slice per cycle on a
// shared external combinational adder, LS slice first, carry chained in a register.
module wide_add_seq #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic [SLICE-1:0] add_a,
  output logic [SLICE-1:0] add_b,
  output logic             add_cin,
  input  logic [SLICE-1:0] add_sum,
  input  logic             add_cout
);

  localparam int unsigned N     = WIDTH / SLICE;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_next_state;
  logic [N-1:0][SLICE-1:0]     r_op_a;
  logic [N-1:0][SLICE-1:0]     r_op_b;
  logic [N-1:0][SLICE-1:0]     r_sum;
  logic                        r_carry;
  logic [IDX_W-1:0]            r_idx;
  logic                        r_cout;
  logic                        r_in_ready;
  logic                        r_out_valid;
  logic                        r_busy;
  logic [SLICE-1:0]            w_add_a;
  logic [SLICE-1:0]            w_add_b;
  logic                        w_add_cin;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and adder-slice selection; slices are driven only while running
  always_comb begin
    w_next_state = r_state;
    w_add_a      = '0;
    w_add_b      = '0;
    w_add_cin    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid && r_in_ready) begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        w_add_a   = r_op_a[r_idx];
        w_add_b   = r_op_b[r_idx];
        w_add_cin = r_carry;
        if (r_idx == LAST_IDX) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operand capture, per-slice result/carry update and registered handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_cout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_next_state == S_IDLE);
      r_out_valid <= (w_next_state == S_DONE);
      r_busy      <= (w_next_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_op_a  <= a;
            r_op_b  <= b;
            r_carry <= cin;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_sum[r_idx] <= add_sum;
          r_carry      <= add_cout;
          if (r_idx == LAST_IDX) begin
            // MSB carry goes only to cout; it never wraps into slice 0
            r_cout <= add_cout;
            r_idx  <= '0;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign add_a     = w_add_a;
  assign add_b     = w_add_b;
  assign add_cin   = w_add_cin;

endmodule
